// File: rtl/mips_pkg.sv
// Shared core definitions: SPECIAL funct codes, muldiv opcodes and FSM states.
package mips_pkg;

  typedef enum logic [5:0] {
    FnSll   = 6'h00,
    FnJr    = 6'h08,
    FnMfhi  = 6'h10,
    FnMthi  = 6'h11,
    FnMflo  = 6'h12,
    FnMtlo  = 6'h13,
    FnMult  = 6'h18,
    FnMultu = 6'h19,
    FnDiv   = 6'h1a,
    FnDivu  = 6'h1b,
    FnAddu  = 6'h21,
    FnSubu  = 6'h23
  } special_funct_e;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } muldiv_state_e;

  function automatic logic op_is_signed(logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/response bundle between decode/execute and the multiply/divide unit.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_is_div,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    w_rem_sh = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    // Remainder after subtract is below the divisor, so WIDTH bits suffice.
    w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;
    if (i_is_div) begin
      if (w_rem_sh >= {1'b0, i_opnd}) o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
      else                            o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end else begin
      if (i_acc[0]) o_acc = {w_sum, i_acc[WIDTH-1:1]};
      else          o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mips_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mips_muldiv
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mips_muldiv_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  muldiv_state_e      r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod_fix;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_fix, w_r_fix, w_res_hi, w_res_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_dz, r_done, r_div_zero;
  logic               w_start_ok, w_arith, w_div, w_sgn, w_b_zero;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .i_is_div (r_is_div),
    .o_acc    (w_acc_step)
  );

  always_comb begin
    w_start_ok = bus.start && !bus.flush && (r_state == StIdle);
    w_arith    = (bus.op <= 3'd3);
    w_div      = (bus.op == OpDiv) || (bus.op == OpDivu);
    w_sgn      = op_is_signed(bus.op);
    w_b_zero   = (bus.b == '0);
    w_a_mag    = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_b_mag    = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // r_neg_q doubles as the product sign for multiplies.
    w_prod_fix = r_neg_q ? -r_acc : r_acc;
    w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (r_dz) begin
      w_res_hi = r_acc[2*WIDTH-1:WIDTH];
      w_res_lo = r_acc[WIDTH-1:0];
    end else if (r_is_div) begin
      w_res_hi = w_r_fix;
      w_res_lo = w_q_fix;
    end else begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: if (w_start_ok && w_arith) w_state_nxt = (w_div && w_b_zero) ? StFix : StRun;
      StRun: begin
        if (bus.flush)                          w_state_nxt = StIdle;
        else if (r_cnt == CNT_W'(WIDTH - 1))    w_state_nxt = StFix;
      end
      StFix:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: if (w_start_ok && bus.op <= 3'd5) begin
          r_div_zero <= 1'b0;
          if (bus.op == OpMthi) begin
            r_hi   <= bus.a;
            r_done <= 1'b1;
          end else if (bus.op == OpMtlo) begin
            r_lo   <= bus.a;
            r_done <= 1'b1;
          end else begin
            r_is_div <= w_div;
            r_cnt    <= '0;
            r_neg_q  <= w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_sgn && bus.a[WIDTH-1];
            r_dz     <= w_div && w_b_zero;
            if (w_div && w_b_zero) begin
              r_acc <= {bus.a, {WIDTH{1'b1}}};
            end else if (w_div) begin
              r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
              r_opnd <= w_b_mag;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
              r_opnd <= w_a_mag;
            end
          end
        end
        StRun: if (!bus.flush) begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        StFix: if (!bus.flush) begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
          if (r_dz) r_div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != StIdle);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv with hand-computed HI/LO results.
module tb_mips_muldiv;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   edges;
  int   busy_cnt;

  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and waits (bounded) for done; edges counts from the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_edges, output int n_busy);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    n_edges   = 1;
    n_busy    = 0;
    while (!bus.done && n_edges < 100) begin
      if (bus.busy) n_busy++;
      tick();
      n_edges++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);

    // MULTU max*max
    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cnt);
    chk("multu_busy", busy_cnt, 33);
    chk("multu_edges", edges, 34);
    chk("multu_res", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    chk("done_pulse", bus.done, 0);

    run_op(OpMult, 32'hFFFF_FFFD, 32'd7, edges, busy_cnt);
    chk("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(OpMult, 32'hFFFF_FFFC, 32'hFFFF_FFFB, edges, busy_cnt);
    chk("mult_negneg", {bus.hi, bus.lo}, 64'h0000_0000_0000_0014);
    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, edges, busy_cnt);
    chk("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OpDivu, 32'd50, 32'd7, edges, busy_cnt);
    chk("divu", {bus.hi, bus.lo}, 64'h0000_0001_0000_0007);

    // Divide by zero short path
    run_op(OpDivu, 32'd100, 32'd0, edges, busy_cnt);
    chk("dz_edges", edges, 2);
    chk("dz_res", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
    chk("dz_flag", bus.div_zero, 1);
    bus.start = 1'b1; bus.op = OpMtlo; bus.a = 32'd5;
    tick();
    bus.start = 1'b0;
    chk("mtlo_done", bus.done, 1);
    chk("mtlo_busy", bus.busy, 0);
    chk("mtlo_dz_clr", bus.div_zero, 0);
    chk("mtlo_res", {bus.hi, bus.lo}, {32'd100, 32'd5});

    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cnt);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_dz", bus.div_zero, 0);

    // Reserved op code does nothing
    bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h1234;
    tick();
    bus.start = 1'b0;
    chk("nop_done", bus.done, 0);
    chk("nop_busy", bus.busy, 0);

    // flush beats start in IDLE
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OpMthi; bus.a = 32'h77;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("idle_flush_done", bus.done, 0);
    chk("idle_flush_hi", bus.hi, 32'h0);

    // Flush mid-RUN, with an ignored start during busy
    bus.start = 1'b1; bus.op = OpDivu; bus.a = 32'd50; bus.b = 32'd7;
    tick();
    bus.start = 1'b0;
    chk("flush_busy0", bus.busy, 1);
    for (int i = 0; i < 10; i++) begin
      if (i >= 2 && i < 5) begin
        bus.start = 1'b1; bus.op = OpMthi; bus.a = 32'hDEAD;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 0);
    chk("flush_done", bus.done, 0);
    chk("flush_hilo", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    tick();
    chk("flush_nodone", bus.done, 0);

    // Reset mid-MULT
    bus.start = 1'b1; bus.op = OpMult; bus.a = 32'd5; bus.b = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);

    // Back-to-back: second start issued in the done cycle
    run_op(OpMult, 32'd5, 32'd6, edges, busy_cnt);
    chk("b2b_first", {bus.hi, bus.lo}, 64'd30);
    run_op(OpMult, 32'h0001_0000, 32'hFFFF_0000, edges, busy_cnt);
    chk("b2b_edges", edges, 34);
    chk("b2b_res", {bus.hi, bus.lo}, 64'hFFFF_FFFF_0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
